// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block fill controller.
//   - fill_state_e      : controller states (IDLE, FILL)
//   - WORDS_PER_BLOCK   : 16-bit words per cache block
//   - OFFSET_W          : width of the word offset within a block
//   - CNT_W             : width of the request/receive counters (one extra bit so
//                         a counter can sit at WORDS_PER_BLOCK without wrapping)
//   - BLOCK_OFFSET_MASK : byte-offset bits cleared to form the block base address
package cache_fill_fsm_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFFSET_W        = 3;
    localparam int CNT_W           = 4;

    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'h000F;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// Saturating word counter used for both outstanding requests and received words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (wins over enable)
//   i_en       : count up by one; ignored once the terminal count is reached
//   o_cnt      : current count
//   o_term     : count has reached TERM
module fill_word_counter #(
    parameter int               CNT_W = 4,
    parameter logic [CNT_W-1:0] TERM  = CNT_W'(8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_term) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == TERM);

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller. On a miss it issues one read request per word of
// the block (back-to-back), then writes each returned word into the data array
// in arrival order and pulses the tag write together with the last word.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   miss_detected       : cache miss this cycle (only accepted in IDLE)
//   miss_address        : byte address of the missing access
//   memory_data_valid   : memory returns a word this cycle
//   memory_data         : returned word
//   fsm_busy            : fill in progress (CPU stall)
//   mem_req             : read request to memory this cycle
//   memory_address      : byte address of the current request
//   write_data_array    : write fill_data into the data array this cycle
//   data_array_word     : word offset being written
//   fill_data           : word being written (pass-through of memory_data)
//   write_tag_array     : one-cycle tag/valid write for the filled block
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a miss; memory responses are ignored
// FILL  | issuing requests and collecting words; leaves on the last word
module cache_fill_fsm
#(
    parameter int WORDS_PER_BLOCK = cache_fill_fsm_pkg::WORDS_PER_BLOCK,
    parameter int ADDR_W          = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   miss_detected,
    input  logic [ADDR_W-1:0]                      miss_address,
    input  logic                                   memory_data_valid,
    input  logic [15:0]                            memory_data,
    output logic                                   fsm_busy,
    output logic                                   mem_req,
    output logic [ADDR_W-1:0]                      memory_address,
    output logic                                   write_data_array,
    output logic [cache_fill_fsm_pkg::OFFSET_W-1:0] data_array_word,
    output logic [15:0]                            fill_data,
    output logic                                   write_tag_array
);

    import cache_fill_fsm_pkg::*;

    fill_state_e      r_state;
    fill_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  w_req_cnt;
    logic [CNT_W-1:0]  w_rcv_cnt;
    logic              w_req_term;
    logic              w_rcv_term;
    logic              w_fill;
    logic              w_start;
    logic              w_req;
    logic              w_wr;
    logic              w_last;

    assign w_fill  = (r_state == ST_FILL);
    assign w_start = (r_state == ST_IDLE) && miss_detected;
    assign w_req   = w_fill && !w_req_term;
    // The receive terminal can never be reached while in FILL (the last word
    // returns to IDLE); gating on it just keeps a stray word from overrunning.
    assign w_wr    = w_fill && memory_data_valid && !w_rcv_term;
    assign w_last  = w_wr && (w_rcv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

    fill_word_counter #(
        .CNT_W (CNT_W),
        .TERM  (CNT_W'(WORDS_PER_BLOCK))
    ) u_req_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_start),
        .i_en   (w_req),
        .o_cnt  (w_req_cnt),
        .o_term (w_req_term)
    );

    fill_word_counter #(
        .CNT_W (CNT_W),
        .TERM  (CNT_W'(WORDS_PER_BLOCK))
    ) u_rcv_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_start),
        .i_en   (w_wr),
        .o_cnt  (w_rcv_cnt),
        .o_term (w_rcv_term)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_IDLE) begin
            if (miss_detected) begin
                w_state_nxt = ST_FILL;
            end
        end else if (w_last) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_base <= miss_address & ~ADDR_W'(BLOCK_OFFSET_MASK);
            end
        end
    end

    // Address is forced to zero outside request cycles so nothing stale is
    // presented to memory; within a request req_cnt < WORDS_PER_BLOCK, so the
    // sum never leaves the block.
    assign fsm_busy         = w_fill;
    assign mem_req          = w_req;
    assign memory_address   = w_req ? (r_base + ADDR_W'({w_req_cnt, 1'b0})) : '0;
    assign write_data_array = w_wr;
    assign data_array_word  = w_wr ? w_rcv_cnt[OFFSET_W-1:0] : '0;
    assign fill_data        = w_wr ? memory_data : '0;
    assign write_tag_array  = w_last;

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  data_array_word;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm #(
        .WORDS_PER_BLOCK (8),
        .ADDR_W          (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_array_word   (data_array_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } pend_t;

    pend_t       pend[$];
    int          t = 0;
    int          last_due = -1;
    int          lat_lo = 4;
    int          lat_hi = 4;
    bit          stray = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;

    logic        s_busy, s_req, s_wr, s_tag;
    logic [15:0] s_addr, s_data;
    logic [2:0]  s_word;

    logic [15:0] exp_base;
    int          sb_req, sb_wr, sb_tag;
    int          rel_first_req, rel_last_req, rel_first_wr, rel_tag, rel_idle;
    logic [15:0] last_req_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h0F0F;
    endfunction

    task automatic drive_mem();
        if (pend.size() > 0 && pend[0].due == t) begin
            memory_data_valid = 1'b1;
            memory_data       = mem_word(pend[0].addr);
            pend.delete(0);
        end else if (stray) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hDEAD;
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'h0000;
        end
    endtask

    // One clock cycle: drive the memory response, sample at the falling edge,
    // queue any request for the memory model, then step past the rising edge.
    task automatic cycle();
        int due;
        drive_mem();
        @(negedge clk);
        s_busy = fsm_busy;
        s_req  = mem_req;
        s_addr = memory_address;
        s_wr   = write_data_array;
        s_word = data_array_word;
        s_data = fill_data;
        s_tag  = write_tag_array;
        if (mem_req) begin
            due = t + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{due, memory_address});
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    // Runs one fill from its first FILL cycle through the first IDLE cycle.
    task automatic fill_check(input logic [15:0] base, input bit hold);
        bit done;
        exp_base      = base;
        sb_req        = 0;
        sb_wr         = 0;
        sb_tag        = 0;
        rel_first_req = -1;
        rel_last_req  = -1;
        rel_first_wr  = -1;
        rel_tag       = -1;
        rel_idle      = -1;
        if (!hold) miss_detected = 1'b0;
        done = 1'b0;
        for (int k = 1; k <= 80 && !done; k++) begin
            cycle();
            if (s_req) begin
                chk("req_addr", s_addr, exp_base + 16'(2 * sb_req));
                if (rel_first_req < 0) rel_first_req = k;
                rel_last_req  = k;
                last_req_addr = s_addr;
                sb_req++;
            end
            if (s_wr) begin
                chk("wr_word", s_word, sb_wr % 8);
                chk("wr_data", s_data, mem_word(exp_base + 16'(2 * sb_wr)));
                chk("tag_on_last", s_tag, (sb_wr == 7));
                if (rel_first_wr < 0) rel_first_wr = k;
                sb_wr++;
            end
            chk("tag_needs_wr", s_tag & ~s_wr, 0);
            if (rel_tag < 0) begin
                chk("busy_in_fill", s_busy, 1);
            end else begin
                chk("busy_after_fill", s_busy, 0);
                rel_idle = k;
                done     = 1'b1;
            end
            if (s_tag) begin
                sb_tag++;
                if (rel_tag < 0) rel_tag = k;
            end
        end
        chk("req_count", sb_req, 8);
        chk("wr_count", sb_wr, 8);
        chk("tag_count", sb_tag, 1);
    endtask

    task automatic miss_cycle(input logic [15:0] addr);
        miss_detected = 1'b1;
        miss_address  = addr;
        cycle();
        chk("idle_busy", s_busy, 0);
        chk("idle_req", s_req, 0);
    endtask

    initial begin
        rst_n             = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0;

        // Reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", fsm_busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", memory_address, 0);
        chk("rst_wr", write_data_array, 0);
        chk("rst_tag", write_tag_array, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed 4-cycle latency: exact cycle positions.
        lat_lo = 4; lat_hi = 4;
        miss_cycle(16'h1236);
        fill_check(16'h1230, 1'b0);
        chk("A_first_req", rel_first_req, 1);
        chk("A_last_req", rel_last_req, 8);
        chk("A_first_wr", rel_first_wr, 5);
        chk("A_tag", rel_tag, 12);
        chk("A_idle", rel_idle, 13);

        // Random latency 1..6, gaps between valids.
        lat_lo = 1; lat_hi = 6;
        miss_cycle(16'h2A5C);
        fill_check(16'h2A50, 1'b0);
        miss_cycle(16'h7777);
        fill_check(16'h7770, 1'b0);

        // Miss held high at another address through a fill.
        lat_lo = 2; lat_hi = 5;
        miss_cycle(16'h0812);
        miss_address = 16'h4000;
        fill_check(16'h0810, 1'b1);
        fill_check(16'h4000, 1'b0);
        chk("C_back_to_back", rel_first_req, 1);

        // Top of address space: no wrap past the block.
        lat_lo = 3; lat_hi = 3;
        miss_cycle(16'hFFFE);
        fill_check(16'hFFF0, 1'b0);
        chk("E_last_addr", last_req_addr, 16'hFFFE);

        // Reset in the middle of a fill.
        lat_lo = 4; lat_hi = 4;
        miss_cycle(16'h5558);
        miss_detected = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            chk("D_tag_early", s_tag, 0);
            chk("D_wr", s_wr, (k >= 5));
        end
        drive_mem();
        chk("D_busy_pre_rst", fsm_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("D_rst_busy", fsm_busy, 0);
        chk("D_rst_req", mem_req, 0);
        chk("D_rst_addr", memory_address, 0);
        chk("D_rst_wr", write_data_array, 0);
        chk("D_rst_tag", write_tag_array, 0);
        @(posedge clk);
        #1;
        t++;
        pend.delete();
        rst_n = 1'b1;
        stray = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("D_stray_wr", s_wr, 0);
            chk("D_stray_tag", s_tag, 0);
            chk("D_stray_busy", s_busy, 0);
        end
        stray = 1'b0;

        // Normal operation after the abandoned fill.
        lat_lo = 1; lat_hi = 4;
        miss_cycle(16'h0024);
        fill_check(16'h0020, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
